// File: rtl/sd_sector_responder.sv
// Sector responder: serves 512-byte sd_buff transfers for two drives from a flat
// byte-wide backing memory addressed as {drive, lba, byte}.
module sd_sector_responder #(
    parameter int LBA_BITS = 15,
    parameter int MEM_AW   = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic [1:0]        sd_rd,
    input  logic [1:0]        sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    input  logic [1:0]        mount_stb,
    input  logic [31:0]       mount_size,
    input  logic              mount_ro,
    output logic [1:0]        img_mounted,
    output logic [31:0]       img_size,
    output logic [1:0]        img_readonly,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_PUSH, S_WR_ADDR, S_WR_CAP, S_WR_MEM, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [22:0]         size_q [2];   // drive size in whole sectors
    logic [1:0]          ro_q;
    logic [1:0]          img_mounted_q;
    logic [31:0]         img_size_q;
    logic                drive_q, wr_q, valid_q;
    logic [LBA_BITS-1:0] lba_q;
    logic [9:0]          cnt_q;
    logic [7:0]          data_q;

    logic accept, sel_drive, sel_wr, valid_d, byte_done, last_byte, req_bit;

    assign last_byte    = (cnt_q == 10'd511);
    assign req_bit      = wr_q ? sd_wr[drive_q] : sd_rd[drive_q];
    assign sd_buff_addr = cnt_q[8:0];
    assign sd_buff_dout = data_q;
    assign mem_wdata    = data_q;
    assign mem_addr     = {drive_q, lba_q, cnt_q[8:0]};
    assign img_mounted  = img_mounted_q;
    assign img_size     = img_size_q;
    assign img_readonly = ro_q;

    // Validity is decided once at acceptance, so a remount mid-transfer only affects later requests.
    assign valid_d = (sd_lba < {9'd0, size_q[sel_drive]}) &&
                     ((sd_lba >> LBA_BITS) == 32'd0) &&
                     !(sel_wr && ro_q[sel_drive]);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d    = state_q;
        accept     = 1'b0;
        sel_drive  = 1'b0;
        sel_wr     = 1'b0;
        byte_done  = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sd_rd[0])      begin sel_drive = 1'b0; sel_wr = 1'b0; end
                else if (sd_wr[0]) begin sel_drive = 1'b0; sel_wr = 1'b1; end
                else if (sd_rd[1]) begin sel_drive = 1'b1; sel_wr = 1'b0; end
                else               begin sel_drive = 1'b1; sel_wr = 1'b1; end
                accept = |{sd_rd, sd_wr};
                if (accept) state_d = sel_wr ? S_WR_ADDR : S_RD_REQ;
            end
            S_RD_REQ: begin
                sd_ack = 1'b1;
                mem_rd = valid_q;
                if (mem_ready || !valid_q) state_d = S_RD_PUSH;
            end
            S_RD_PUSH: begin
                sd_ack     = 1'b1;
                sd_buff_wr = 1'b1;
                byte_done  = 1'b1;
                state_d    = last_byte ? S_DONE : S_RD_REQ;
            end
            S_WR_ADDR: begin
                sd_ack  = 1'b1;
                state_d = S_WR_CAP;
            end
            S_WR_CAP: begin
                sd_ack  = 1'b1;
                state_d = S_WR_MEM;
            end
            S_WR_MEM: begin
                sd_ack = 1'b1;
                mem_wr = valid_q;
                if (mem_ready || !valid_q) begin
                    byte_done = 1'b1;
                    state_d   = last_byte ? S_DONE : S_WR_ADDR;
                end
            end
            S_DONE: begin
                // Hold here until the requester drops the served bit, so it is not served twice.
                if (!req_bit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            size_q[0]     <= '0;
            size_q[1]     <= '0;
            ro_q          <= '0;
            img_mounted_q <= '0;
            img_size_q    <= '0;
            drive_q       <= 1'b0;
            wr_q          <= 1'b0;
            valid_q       <= 1'b0;
            lba_q         <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            img_mounted_q <= mount_stb;
            if (|mount_stb) img_size_q <= mount_size;
            for (int d = 0; d < 2; d++) begin
                if (mount_stb[d]) begin
                    size_q[d] <= mount_size[31:9];
                    ro_q[d]   <= mount_ro;
                end
            end
            if (accept) begin
                drive_q <= sel_drive;
                wr_q    <= sel_wr;
                lba_q   <= sd_lba[LBA_BITS-1:0];
                valid_q <= valid_d;
                cnt_q   <= '0;
            end
            if (state_q == S_RD_REQ && (mem_ready || !valid_q))
                data_q <= valid_q ? mem_rdata : 8'h00;
            if (state_q == S_WR_CAP)
                data_q <= sd_buff_din;
            if (byte_done)
                cnt_q <= last_byte ? 10'd0 : cnt_q + 10'd1;
        end
    end

endmodule

// File: tb/tb_sd_sector_responder.sv
// Randomized self-checking bench for sd_sector_responder: a requester, a stalling
// backing memory and a sector-level reference model of drive sizes and contents.
module tb_sd_sector_responder;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [1:0]  mount_stb;
    logic [31:0] mount_size;
    logic        mount_ro;
    logic [1:0]  img_mounted;
    logic [31:0] img_size;
    logic [1:0]  img_readonly;
    logic [24:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    sd_sector_responder dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mount_stb(mount_stb),
        .mount_size(mount_size), .mount_ro(mount_ro), .img_mounted(img_mounted),
        .img_size(img_size), .img_readonly(img_readonly), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    logic [89:0] outs_cat;
    assign outs_cat = {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_mounted, img_size,
                       img_readonly, mem_addr, mem_rd, mem_wr, mem_wdata};

    int vectors = 0;
    int miscompares = 0;

    // Reference model and environment state
    logic [31:0] size_m [2];
    logic        ro_m   [2];
    logic [7:0]  mem_m  [int];
    logic [7:0]  wbuf   [512];
    logic [16:0] push_q [$];
    int          rd_cnt = 0, wr_cnt = 0, proto_err = 0, max_stall = 0;
    bit          in_op = 0;
    int          wait_cnt = 0;
    logic [24:0] held_addr;
    logic [7:0]  held_wdata;
    bit          held_rd;
    logic [8:0]  prev_addr = '0;
    int          pb, rb, wb, peb, alen;

    function automatic logic [7:0] mem_get(input int a);
        return mem_m.exists(a) ? mem_m[a] : 8'h00;
    endfunction

    function automatic int maddr(input int d, input logic [31:0] lba, input int k);
        return d * 32'h100_0000 + int'(lba % 32'd32768) * 512 + k;
    endfunction

    function automatic bit lba_ok(input int d, input logic [31:0] lba);
        return (lba < (size_m[d] >> 9)) && (lba < 32'd32768);
    endfunction

    // Requester buffer and stalling memory, sampled on the falling edge
    task automatic monitor();
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                in_op     = 0;
                mem_ready = 1'b0;
            end else begin
                if (sd_buff_wr) begin
                    push_q.push_back({sd_buff_addr, sd_buff_dout});
                    if (!sd_ack) proto_err++;
                end
                if (mem_rd && mem_wr) proto_err++;
                if (mem_rd || mem_wr) begin
                    if (!in_op) begin
                        in_op      = 1;
                        held_addr  = mem_addr;
                        held_wdata = mem_wdata;
                        held_rd    = mem_rd;
                        wait_cnt   = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
                    end else if (mem_addr !== held_addr || mem_rd !== held_rd ||
                                 (mem_wr && mem_wdata !== held_wdata)) begin
                        proto_err++;
                    end
                    if (wait_cnt == 0) begin
                        mem_ready = 1'b1;
                        in_op     = 0;
                        if (mem_rd) begin
                            mem_rdata = mem_get(int'(mem_addr));
                            rd_cnt++;
                        end else begin
                            mem_m[int'(mem_addr)] = mem_wdata;
                            wr_cnt++;
                        end
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = 8'($urandom);
                        wait_cnt--;
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'($urandom);
                end
                sd_buff_din = wbuf[prev_addr];
                prev_addr   = sd_buff_addr;
            end
        end
    endtask

    task automatic mount(input int d, input logic [31:0] size, input logic ro);
        @(negedge clk_sys);
        mount_stb  = 2'(1 << d);
        mount_size = size;
        mount_ro   = ro;
        @(negedge clk_sys);
        mount_stb = 2'b00;
        size_m[d] = size;
        ro_m[d]   = ro;
        vectors++;
        if (img_mounted !== 2'(1 << d)) begin
            miscompares++; $display("FAIL mount_pulse: got %b want %b", img_mounted, 2'(1 << d));
        end
        vectors++;
        if (img_size !== size) begin
            miscompares++; $display("FAIL mount_size: got %h want %h", img_size, size);
        end
        vectors++;
        if (img_readonly[d] !== ro) begin
            miscompares++; $display("FAIL mount_ro: got %b want %b", img_readonly[d], ro);
        end
        @(negedge clk_sys);
        vectors++;
        if (img_mounted !== 2'b00) begin
            miscompares++; $display("FAIL mount_pulse_len: got %b want 00", img_mounted);
        end
    endtask

    // One complete request/ack handshake; snapshots counters into pb/rb/wb/peb and ack length into alen
    task automatic run_xfer(input int d, input bit wr, input logic [31:0] lba);
        int n;
        @(negedge clk_sys);
        pb = push_q.size(); rb = rd_cnt; wb = wr_cnt; peb = proto_err;
        sd_lba = lba;
        if (wr) sd_wr[d] = 1'b1; else sd_rd[d] = 1'b1;
        n = 0;
        while (!sd_ack && n < 50) begin @(negedge clk_sys); n++; end
        vectors++;
        if (!sd_ack) begin miscompares++; $display("FAIL ack_rise: got 0 want 1"); end
        sd_rd = 2'b00; sd_wr = 2'b00; sd_lba = $urandom;
        n = 1;
        while (n < 20000) begin
            @(negedge clk_sys);
            if (!sd_ack) break;
            n++;
        end
        alen = n;
        vectors++;
        if (sd_ack) begin miscompares++; $display("FAIL ack_fall: ack still high after %0d cycles", n); end
        repeat (3) @(negedge clk_sys);
        vectors++;
        if (sd_ack !== 1'b0) begin miscompares++; $display("FAIL reserve: ack got %b want 0", sd_ack); end
        vectors++;
        if (proto_err != peb) begin
            miscompares++; $display("FAIL protocol: %0d strobe violations, want 0", proto_err - peb);
        end
    endtask

    task automatic check_read(input int d, input logic [31:0] lba);
        bit v = lba_ok(d, lba);
        logic [7:0] e;
        vectors++;
        if (push_q.size() - pb != 512) begin
            miscompares++; $display("FAIL rd_count: got %0d strobes want 512", push_q.size() - pb);
        end
        for (int k = 0; k < 512 && pb + k < push_q.size(); k++) begin
            e = v ? mem_get(maddr(d, lba, k)) : 8'h00;
            vectors++;
            if (push_q[pb + k] !== {9'(k), e}) begin
                miscompares++;
                $display("FAIL rd_byte %0d: got addr %0d data %h want addr %0d data %h", k,
                         push_q[pb + k][16:8], push_q[pb + k][7:0], k, e);
            end
        end
        vectors++;
        if (rd_cnt - rb != (v ? 512 : 0)) begin
            miscompares++; $display("FAIL rd_memops: got %0d want %0d", rd_cnt - rb, v ? 512 : 0);
        end
        vectors++;
        if (wr_cnt != wb) begin miscompares++; $display("FAIL rd_nowr: got %0d mem_wr want 0", wr_cnt - wb); end
        if (max_stall == 0) begin
            vectors++;
            if (alen != 1024) begin miscompares++; $display("FAIL rd_latency: got %0d want 1024", alen); end
        end
    endtask

    task automatic check_write(input int d, input logic [31:0] lba);
        bit v = lba_ok(d, lba) && !ro_m[d];
        vectors++;
        if (push_q.size() != pb) begin
            miscompares++; $display("FAIL wr_buffwr: got %0d strobes want 0", push_q.size() - pb);
        end
        vectors++;
        if (wr_cnt - wb != (v ? 512 : 0)) begin
            miscompares++; $display("FAIL wr_memops: got %0d want %0d", wr_cnt - wb, v ? 512 : 0);
        end
        if (v) begin
            for (int k = 0; k < 512; k++) begin
                vectors++;
                if (mem_get(maddr(d, lba, k)) !== wbuf[k]) begin
                    miscompares++;
                    $display("FAIL wr_byte %0d: got %h want %h", k, mem_get(maddr(d, lba, k)), wbuf[k]);
                end
            end
        end
        if (max_stall == 0) begin
            vectors++;
            if (alen != 1536) begin miscompares++; $display("FAIL wr_latency: got %0d want 1536", alen); end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (outs_cat !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", outs_cat); end
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        size_m[0] = '0; size_m[1] = '0; ro_m[0] = 0; ro_m[1] = 0;
    endtask

    task automatic test_read_basic();
        mount(0, 32'h10000, 1'b0);
        for (int k = 0; k < 512; k++) mem_m[maddr(0, 5, k)] = 8'(k) ^ 8'h5A;
        max_stall = 0;
        run_xfer(0, 1'b0, 5);
        check_read(0, 5);
    endtask

    task automatic test_write_d1();
        mount(1, 32'h100000, 1'b0);
        for (int k = 0; k < 512; k++) wbuf[k] = ~8'(k);
        max_stall = 0;
        run_xfer(1, 1'b1, 3);
        check_write(1, 3);
    endtask

    task automatic test_stall_read();
        for (int k = 0; k < 512; k++) mem_m[maddr(1, 7, k)] = 8'($urandom);
        max_stall = 7;
        run_xfer(1, 1'b0, 7);
        check_read(1, 7);
        max_stall = 0;
    endtask

    task automatic test_invalid();
        mount(0, 32'h10000, 1'b1);
        run_xfer(0, 1'b1, 2);
        check_write(0, 2);
        run_xfer(0, 1'b0, 128);
        check_read(0, 128);
        for (int k = 0; k < 512; k++) mem_m[maddr(0, 127, k)] = 8'($urandom);
        run_xfer(0, 1'b0, 127);
        check_read(0, 127);
        mount(1, 32'hFFFF_FE00, 1'b0);
        run_xfer(1, 1'b0, 32768);
        check_read(1, 32768);
    endtask

    task automatic test_priority();
        int  exp_d [3] = '{0, 0, 1};
        bit  exp_w [3] = '{0, 1, 0};
        int  n, dd;
        bit  ww;
        mount(0, 32'h10000, 1'b0);
        @(negedge clk_sys);
        sd_lba = 1; sd_rd = 2'b11; sd_wr = 2'b01;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            while (!(mem_rd || mem_wr) && n < 60) begin @(negedge clk_sys); n++; end
            dd = int'(mem_addr[24]); ww = mem_wr;
            vectors++;
            if (!(mem_rd || mem_wr) || dd != exp_d[t] || ww != exp_w[t]) begin
                miscompares++;
                $display("FAIL priority %0d: got drive %0d wr %0b want drive %0d wr %0b",
                         t, dd, ww, exp_d[t], exp_w[t]);
            end
            if (ww) sd_wr[dd] = 1'b0; else sd_rd[dd] = 1'b0;
            n = 0;
            while (sd_ack && n < 5000) begin @(negedge clk_sys); n++; end
        end
        sd_rd = 2'b00; sd_wr = 2'b00;
        repeat (3) @(negedge clk_sys);
        vectors++;
        if (sd_ack !== 1'b0) begin miscompares++; $display("FAIL priority_end: ack got %b want 0", sd_ack); end
    endtask

    task automatic test_reset_mid();
        int n;
        int base;
        max_stall = 0;
        @(negedge clk_sys);
        base = push_q.size();
        sd_lba = 5; sd_rd = 2'b01;
        n = 0;
        while (!sd_ack && n < 50) begin @(negedge clk_sys); n++; end
        sd_rd = 2'b00;
        n = 0;
        while (push_q.size() - base < 200 && n < 2000) begin @(negedge clk_sys); n++; end
        vectors++;
        if (push_q.size() - base < 200) begin miscompares++; $display("FAIL midreset_progress: got %0d bytes want 200", push_q.size() - base); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (outs_cat !== '0) begin miscompares++; $display("FAIL midreset_outputs: got %h want 0", outs_cat); end
        size_m[0] = '0; size_m[1] = '0; ro_m[0] = 0; ro_m[1] = 0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        vectors++;
        if ({sd_ack, mem_rd, mem_wr, sd_buff_wr} !== 4'b0) begin
            miscompares++; $display("FAIL midreset_idle: got %b want 0000", {sd_ack, mem_rd, mem_wr, sd_buff_wr});
        end
        mount(0, 32'h10000, 1'b0);
        run_xfer(0, 1'b0, 5);
        check_read(0, 5);
    endtask

    task automatic test_random();
        int d;
        bit wr;
        logic [31:0] lba;
        mount(0, 32'h10000, 1'($urandom));
        mount(1, (32'($urandom_range(0, 300)) << 9) | 32'($urandom_range(0, 511)), 1'($urandom));
        for (int t = 0; t < 6; t++) begin
            d = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            lba = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 320));
            max_stall = int'($urandom_range(0, 7));
            if (wr) for (int k = 0; k < 512; k++) wbuf[k] = 8'($urandom);
            else    for (int k = 0; k < 512; k++) mem_m[maddr(d, lba, k)] = 8'($urandom);
            run_xfer(d, wr, lba);
            if (wr) check_write(d, lba); else check_read(d, lba);
        end
        max_stall = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sd_lba = '0; sd_rd = '0; sd_wr = '0; mount_stb = '0; mount_size = '0; mount_ro = 1'b0;
        sd_buff_din = '0; mem_rdata = '0; mem_ready = 1'b0;
        for (int k = 0; k < 512; k++) wbuf[k] = '0;
        test_reset();
        fork monitor(); join_none
        test_read_basic();
        test_write_d1();
        test_stall_read();
        test_invalid();
        test_priority();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Serves the core's sector interface (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*): it is the responder for a disk controller's sector requests.
- Each 512-byte sector maps onto a flat byte-wide backing memory, for example SDRAM via an arbiter or a BRAM RAM-disk.
- Used for RAM-disk builds and as the bench-side model of the SPI IO controller's sector service.
- Handles two drives, with per-drive size and read-only attributes.

Parameters:
- LBA_BITS, 15, sector-index bits stored per drive.
- MEM_AW, 25, backing memory address width; must equal 1+LBA_BITS+9.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sd_lba  in  32  sector number; sampled when a request is accepted.
- sd_rd  in  2  per-drive read request, level.
- sd_wr  in  2  per-drive write request, level.
- sd_ack  out  1  high for the whole transfer.
- sd_buff_addr  out  9  byte index within the sector.
- sd_buff_dout  out  8  read data to the requester.
- sd_buff_wr  out  1  one-cycle strobe qualifying sd_buff_dout/sd_buff_addr.
- sd_buff_din  in  8  write data from the requester; valid 1 cycle after sd_buff_addr.
- mount_stb  in  2  per-drive pulse: latch drive attributes.
- mount_size  in  32  image size in bytes, latched on mount_stb.
- mount_ro  in  1  read-only flag, latched on mount_stb.
- img_mounted  out  2  one-cycle pulse, 1 cycle after mount_stb.
- img_size  out  32  size of the most recently mounted drive.
- img_readonly  out  2  per-drive read-only flag.
- mem_addr  out  MEM_AW  {drive, lba[LBA_BITS-1:0], byte[8:0]}.
- mem_rd  out  1  read strobe; held until mem_ready.
- mem_wr  out  1  write strobe; held until mem_ready.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid in the cycle mem_ready is high.
- mem_ready  in  1  completes the current mem_rd/mem_wr in that cycle; may be high in the first strobe cycle.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs are 0.
  - Per-drive sizes are 0 and read-only flags are 0.
  - FSM goes to IDLE and any transfer in progress is abandoned without completion.
- Mount:
  - mount_stb[d] latches size and ro for drive d.
  - Next cycle: img_mounted[d]=1 for exactly one cycle, img_size updates and img_readonly[d] updates.
  - A mount during a transfer to the same drive takes effect only on the next request.
- Request selection, in IDLE:
  - Priority order: sd_rd[0], sd_wr[0], sd_rd[1], sd_wr[1].
  - Latch drive, direction and sd_lba, then go to ACK; sd_ack=1 from the next cycle onward.
- Valid flag: valid = (lba < size>>9) AND (lba < 2^LBA_BITS).
  - Write additionally requires the drive to be not read-only.
  - When invalid: a read delivers 0x00 bytes with no mem access; a write consumes all 512 bytes with no mem access.
  - Every transfer always moves exactly 512 bytes.
- READ loop, i = 0..511:
  - RD_REQ: mem_rd=1 with mem_addr for byte i, held until mem_ready; capture mem_rdata.
  - RD_PUSH: one cycle with sd_buff_addr=i, sd_buff_dout=data, sd_buff_wr=1.
  - Then i+1.
- WRITE loop, i = 0..511:
  - WR_ADDR: sd_buff_addr=i.
  - WR_CAP (next cycle): capture sd_buff_din.
  - WR_MEM: mem_wr=1 with mem_wdata, held until mem_ready.
  - Then i+1.
- Counter: a 10-bit counter ends the transfer when i=511 completes. sd_buff_addr never wraps within a transfer.
- DONE:
  - sd_ack=0.
  - Wait until the latched request bit is low, then go to IDLE. This prevents the same request from being re-served.
  - The requester drops its request when it sees sd_ack=1.
- Strobe rules:
  - mem_rd and mem_wr are never both high.
  - mem_addr and mem_wdata stay stable while a strobe is held.
  - sd_buff_wr is only high during READ.
- Latency with mem_ready tied high:
  - Read: 2 cycles/byte; sd_ack to the last sd_buff_wr is 1024 cycles.
  - Write: 3 cycles/byte.
- Simultaneous events:
  - Other requests arriving during a transfer are ignored until IDLE and are then arbitrated.
  - sd_lba changes after acceptance have no effect.

Test Plan:
- Mount drive0 size=0x10000, ro=0; preload mem[{0,lba=5}] bytes k→k^0x5A; pulse sd_rd=01, lba=5 → img_mounted=01 pulse; sd_ack high; 512 sd_buff_wr strobes, addr 0..511, dout=k^0x5A; sd_ack low; return to IDLE after sd_rd drops.
- Drive1 write, lba=3, requester buffer din=~addr[7:0] → mem[{1,3,k}]=~k for all k; mem_wr count=512; no sd_buff_wr.
- Random mem_ready stalls of 0–7 cycles on a read → identical data; each strobe held until ready; address stable while stalled.
- Drive0 ro=1 write, and drive0 read at lba=128 with size=0x10000 → no mem_wr/mem_rd; read yields 512×0x00; both transfers still complete with sd_ack.
- sd_rd=11 and sd_wr=01 asserted simultaneously → drive0 read served first; drive0 write next; then drive1 read.
- reset_n low at byte 200 of a read → all outputs 0 immediately; after release with requests low, FSM is in IDLE; a new request completes normally.
